// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store to BASE_ADDR queues a byte, BASE_ADDR+1 clears overflow.
// Latency: store at edge E is counted at E, popped and start bit driven at E+1 when idle; tx is registered.
// Backpressure: none upstream; a store to a full FIFO is dropped and sets sticky overflow. Option macro: UART_TX_PARITY_EN.
module io_uart_tx #(
    parameter int          CPU_WIDTH    = 16,
    parameter int unsigned BASE_ADDR    = 'h4000,
    parameter int          CLKS_PER_BIT = 217,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CPU_WIDTH-1:0] io_addr,
    input  logic                 io_write,
    input  logic [CPU_WIDTH-1:0] io_wr_data,
    output logic [CPU_WIDTH-1:0] io_rd_data,
    output logic                 tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CPU_WIDTH-1:0] DATA_ADDR = CPU_WIDTH'(BASE_ADDR);
    localparam logic [CPU_WIDTH-1:0] CTRL_ADDR = CPU_WIDTH'(BASE_ADDR + 1);
    localparam logic [11:0]          TMAX      = 12'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]        FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

    state_t          state, state_nxt;
    logic [11:0]     timer, timer_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            tx_nxt;
    logic            pop;
    logic            bit_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, overflow;
    logic            push_req, push, clr_ovf;
    logic [7:0]      head;
    logic            unused_wr_hi;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_req = io_write && (io_addr == DATA_ADDR);
    // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
    assign push     = push_req && !full;
    assign clr_ovf  = io_write && (io_addr == CTRL_ADDR);
    assign head     = mem[rd_ptr];
    assign bit_end  = (timer == TMAX);
    assign unused_wr_hi = ^io_wr_data[CPU_WIDTH-1:8];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= io_wr_data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par, par_nxt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) par <= 1'b0;
        else        par <= par_nxt;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 12'd1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = tx;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^head;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    timer_nxt   = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                    tx_nxt      = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = shift >> 1;
                        tx_nxt      = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_nxt   = ^head;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_comb begin
        io_rd_data = '0;
        if (io_addr == DATA_ADDR) begin
            io_rd_data[0]   = (state != IDLE);
            io_rd_data[1]   = full;
            io_rd_data[2]   = empty;
            io_rd_data[3]   = overflow;
            io_rd_data[8:4] = 5'(count);
`ifdef UART_TX_PARITY_EN
            io_rd_data[9]   = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomised bench for io_uart_tx against a frame-level model (byte queue plus per-frame bit vector).
module tb_io_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h4000;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif
    localparam logic [15:0] PAR_MASK = {6'b0, PAR, 9'b0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] io_addr = BASE;
    logic        io_write = 1'b0;
    logic [15:0] io_wr_data = '0;
    logic [15:0] io_rd_data;
    logic        tx;

    always #5 clock = ~clock;

    io_uart_tx #(
        .CPU_WIDTH(16), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .io_addr(io_addr), .io_write(io_write),
        .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .tx(tx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: queued bytes, the frame on the wire and its start edge.
    logic [7:0]  mq[$];
    bit          m_active = 0;
    bit          m_ovf = 0;
    int          m_start = 0;
    int          cyc = 0;
    logic [10:0] m_frame = '1;
    logic        last_tx;
    logic [15:0] last_rd;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PAR) f[9] = ^b;
        return f;
    endfunction

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        return m_frame[(cyc - m_start) / CPB];
    endfunction

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        logic [15:0] s;
        if (a != BASE) return 16'h0000;
        s = PAR_MASK;
        s[0] = m_active;
        s[1] = (mq.size() == DEPTH);
        s[2] = (mq.size() == 0);
        s[3] = m_ovf;
        s[8:4] = 5'(mq.size());
        return s;
    endfunction

    task automatic model_edge(input bit w, input logic [15:0] a, input logic [15:0] d);
        int pre;
        pre = mq.size();
        cyc++;
        if (m_active && (cyc - m_start == NBITS * CPB)) m_active = 0;
        if (!m_active && mq.size() > 0) begin
            m_frame  = frame_of(mq.pop_front());
            m_active = 1;
            m_start  = cyc;
        end
        if (w && a == BASE) begin
            if (pre == DEPTH) m_ovf = 1;
            else              mq.push_back(d[7:0]);
        end
        if (w && a == BASE + 16'd1) m_ovf = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_ovf    = 0;
    endtask

    task automatic step(input bit w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        io_write = w; io_addr = a; io_wr_data = d;
        #1;
        last_tx = tx;
        last_rd = io_rd_data;
        check("tx", tx, exp_tx());
        check("rd_data", io_rd_data, exp_rd(a));
        @(posedge clock);
        model_edge(w, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE, 16'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        io_write = 1'b0; io_addr = BASE;
        #2 reset = 1'b0;
        #1 model_reset();
        check("rst_tx", tx, 1'b1);
        check("rst_status", io_rd_data, 16'h0004 | PAR_MASK);
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [8:0] a5_pat;
        int busy_n;
        a5_pat = 9'h14A;

        // Reset state
        #12;
        check("por_tx", tx, 1'b1);
        check("por_status", io_rd_data, 16'h0004 | PAR_MASK);
        @(negedge clock); #1 reset = 1'b1;
        idle(3);

        // Single byte 0xA5: explicit start+data bit pattern, and busy duration
        step(1'b1, BASE, 16'h00A5);
        idle(1);
        busy_n = 0;
        for (int j = 0; j < NBITS; j++) begin
            for (int k = 0; k < CPB; k++) begin
                step(1'b0, BASE, 16'h0);
                if (last_rd[0]) busy_n++;
                if (k == 1 && j < 9) check("a5_bit", last_tx, a5_pat[j]);
            end
        end
        idle(3);
        check("a5_busy_cycles", busy_n, NBITS * CPB);

        // Back-to-back frames with no gap
        step(1'b1, BASE, 16'h0001);
        step(1'b1, BASE, 16'h0002);
        busy_n = 0;
        for (int i = 0; i < 2 * NBITS * CPB + 4; i++) begin
            step(1'b0, BASE, 16'h0);
            if (last_rd[0]) busy_n++;
        end
        check("b2b_busy_cycles", busy_n, 2 * NBITS * CPB);

        // Overflow: six stores while the first frame starts
        for (int i = 0; i < 6; i++) step(1'b1, BASE, 16'($urandom));
        step(1'b0, BASE, 16'h0);
        check("ovf_status", last_rd, 16'h004B | PAR_MASK);
        step(1'b1, BASE + 16'd1, 16'hFFFF);
        step(1'b0, BASE, 16'h0);
        check("ovf_cleared", last_rd, 16'h0043 | PAR_MASK);
        idle(5 * NBITS * CPB + 4);

        // Reset in the middle of the data bits, then a clean frame
        step(1'b1, BASE, 16'h0055);
        step(1'b1, BASE, 16'h00AA);
        idle(3 * CPB);
        pulse_reset();
        idle(2);
        step(1'b1, BASE, 16'h00C3);
        idle(NBITS * CPB + 4);

        // Parity byte with three ones
        step(1'b1, BASE, 16'h0007);
        idle(NBITS * CPB + 4);

        // Random traffic across data, control and unrelated addresses
        for (int i = 0; i < 900; i++) begin
            logic [15:0] a;
            int r;
            r = $urandom_range(0, 7);
            if (r <= 4)      a = BASE;
            else if (r == 5) a = BASE + 16'd1;
            else if (r == 6) a = 16'($urandom);
            else             a = BASE - 16'd1;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else step(($urandom_range(0, 5) == 0), a, 16'($urandom));
        end
        idle((DEPTH + 1) * NBITS * CPB + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter on the stack machine's I/O bus. It decodes CPU store and load cycles at two addresses, buffers written bytes in a small FIFO, and serialises them as 8N1 frames on the board's TX pin. It sits directly downstream of the CPU's `io_addr` / `io_write` / `io_wr_data` outputs. It drives the CPU's `io_rd_data` input with a status word.

## Interface
- `BASE_ADDR`, 16'h4000: data/status register address; `BASE_ADDR+1` is the control register. Both must have a nonzero top-2-bit field so the CPU routes them to I/O.
- `CLKS_PER_BIT`, 217: clocks per serial bit (25 MHz / 115200). Legal range 2..4095.
- `FIFO_DEPTH`, 8: byte FIFO depth. Must be a power of two, 2..16.
- `clock`  in  1: single clock for all logic.
- `reset`  in  1: asynchronous, active-low; 0 forces reset state immediately.
- `io_addr`  in  `CPU_WIDTH`: CPU I/O address, valid every cycle.
- `io_write`  in  1: store strobe, sampled at the rising edge.
- `io_wr_data`  in  `CPU_WIDTH`: store data; only [7:0] used.
- `io_rd_data`  out  `CPU_WIDTH`: combinational read data for the current `io_addr`.
- `tx`  out  1: serial output, idle high.

## Operation
- Write to `BASE_ADDR`:
  - Pushes `io_wr_data[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and sticky `overflow` is set.
  - A pop in the same cycle does not rescue a push to a full FIFO.
- Write to `BASE_ADDR+1`: clears `overflow`; data is ignored.
- Read of `BASE_ADDR` returns status:
  - bit0 `busy` (FSM not IDLE); bit1 `full`; bit2 `empty`; bit3 `overflow`.
  - bits[8:4]: FIFO count (0..16).
  - Upper bits are 0.
- Read of any other address returns 0.
- Address match is an exact full-width compare.
- The FIFO is circular, with read/write pointers wrapping modulo `FIFO_DEPTH` and a separate count register.
  - Simultaneous push (not full) and pop leaves the count unchanged.
- FSM states and transitions:
  - IDLE → START: when FIFO is non-empty. Pops the head into the shift register; `tx`=0.
  - START → DATA: after `CLKS_PER_BIT` cycles.
  - DATA: shifts 8 bits LSB first, `CLKS_PER_BIT` cycles each, then moves to STOP (or PARITY, see Configuration).
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At its last cycle:
    - FIFO non-empty: pop and go straight to START (back-to-back frames, no gap).
    - Otherwise: go to IDLE.
- Counters:
  - Bit timer counts 0..`CLKS_PER_BIT`-1 and resets on each bit boundary.
  - Bit index counts 0..7.
  - `tx` is registered, not combinational.
- Reset, whether mid-frame or otherwise:
  - Empties the FIFO and clears `overflow`.
  - Returns the FSM to IDLE and `tx` to 1. The partial frame is abandoned.
  - `io_rd_data` at `io_addr`=`BASE_ADDR` reads 16'h0004.

## Timing
- Write latency:
  - A store sampled at edge E appears in the FIFO count after E.
  - If the FSM is idle, it pops at edge E+1 and `tx` falls at E+1.
- The start bit is low for exactly `CLKS_PER_BIT` clocks.
- A frame is exactly 10×`CLKS_PER_BIT` clocks (11× with parity).
- Back-to-back frames have zero idle clocks between the stop bit and the next start bit.
- `busy` is 1 from E+1 through the last STOP cycle.
- `io_rd_data` is purely combinational from `io_addr` and the current registers. The CPU samples it at the same edge it issues the load.
- Status reflects register state before the current edge's updates; there is no read side effect.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state follows DATA and drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame is 11 bits.
  - Status bit9 reads 1.
- Undefined: no PARITY state, 10-bit 8N1 frame, status bit9 reads 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Reset then read `BASE_ADDR` → `io_rd_data`=16'h0004 and `tx`=1.
- Write 8'hA5 → `tx` reads, 4 clocks each: 0,1,0,1,0,0,1,0,1,1 (LSB first). Total 40 clocks; `busy` falls after the stop bit.
- Write 8'h01, 8'h02 on consecutive stores → second start bit begins on the clock right after the first stop bit ends; 80 clocks total with no gap.
- Six writes while the first frame is starting → first byte in the shifter, 4 in the FIFO, one dropped.
  - Status: full=1, overflow=1, count=4.
  - Write `BASE_ADDR+1` → overflow=0, other bits unchanged.
- Assert `reset`=0 for one cycle mid-DATA of a frame → `tx`=1 immediately (asynchronous), FIFO empty, FSM IDLE; the next write transmits cleanly.
- With `UART_TX_PARITY_EN` defined, write 8'h07 → parity bit 1 (three ones) between data and stop; frame is 44 clocks; status bit9=1.
